data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 23 ++
 rtl/cache_line_array.sv | 45 ++++
 rtl/data_cache.sv | 140 ++++++++++++++
 tb/tb_data_cache.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped, write-through data cache.
// The top-level parameters default to the values held here.
package data_cache_pkg;

  localparam logic [31:0] DC_BASE_ADDR = 32'd1024;
  localparam int unsigned DC_LINES     = 64;
  localparam int unsigned DC_INDEX_W   = $clog2(DC_LINES);
  // The tag covers offset bits [17:INDEX_W+2].
  localparam int unsigned DC_TAG_W     = 16 - DC_INDEX_W;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FILL       = 2'd1,
    ST_WRITE_THRU = 2'd2
  } dc_state_e;

  // The byte offset into data memory wraps modulo 2^32.
  function automatic logic [31:0] dc_offset(input logic [31:0] addr,
                                            input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for the one-word cache lines.
// It has one combinational read port and one write port. Valid bits clear synchronously.
module cache_line_array #(
  parameter int unsigned LINES   = 64,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 10,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Only the valid bits are reset. Stale tags and data are harmless once their valid bit is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-line data cache for the MEM stage.
// Loads hit with no added latency. Stores are write-through and no-write-allocate.
module data_cache
  import data_cache_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DC_BASE_ADDR,
  parameter int unsigned LINES     = DC_LINES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] readData,
  output logic        stall,
  output logic [31:0] sramAddr,
  output logic [31:0] sramWriteData,
  output logic        sramRead,
  output logic        sramWrite,
  input  logic        sramReady,
  input  logic [31:0] sramReadData
);

  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned TAG_W   = 16 - INDEX_W;

  logic [31:0]        offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               unused_offset_bits;

  assign offset             = dc_offset(address, BASE_ADDR);
  assign index              = offset[INDEX_W+1:2];
  assign tag                = offset[17:INDEX_W+2];
  assign unused_offset_bits = ^{offset[31:18], offset[1:0]};

  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [31:0]        line_data;
  logic               hit;
  logic               arr_wr_en;
  logic [31:0]        arr_wr_data;

  cache_line_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (32)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (arr_wr_en),
    .wr_index (index),
    .wr_tag   (tag),
    .wr_data  (arr_wr_data)
  );

  assign hit = line_valid && (line_tag == tag);

  dc_state_e state_q;
  dc_state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Backing handshake: sramRead or sramWrite is a request. Address and data stay
  // stable while it is held. The access completes in the first cycle where the
  // request and sramReady are both 1. The request and the pipeline stall both drop
  // in that same cycle.
  assign sramAddr      = address;
  assign sramWriteData = data;

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    sramRead    = 1'b0;
    sramWrite   = 1'b0;
    readData    = 32'd0;
    arr_wr_en   = 1'b0;
    arr_wr_data = data;

    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          // When both requests are set, the access is treated as a store.
          if (memWrite) begin
            state_d = ST_WRITE_THRU;
            stall   = 1'b1;
          end else if (memRead) begin
            if (hit) begin
              readData = line_data;
            end else begin
              state_d = ST_FILL;
              stall   = 1'b1;
            end
          end
        end

        ST_FILL: begin
          sramRead = 1'b1;
          if (sramReady) begin
            readData    = memRead ? sramReadData : 32'd0;
            arr_wr_en   = 1'b1;
            arr_wr_data = sramReadData;
            state_d     = ST_IDLE;
          end else begin
            stall = 1'b1;
          end
        end

        ST_WRITE_THRU: begin
          sramWrite = 1'b1;
          if (sramReady) begin
            // A write hit refreshes the cached copy. A write miss does not allocate a line.
            arr_wr_en   = hit;
            arr_wr_data = data;
            state_d     = ST_IDLE;
          end else begin
            stall = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache. The bench drives inputs on the falling edge and samples outputs 1 ns later.
// The backing memory responds after a latency chosen per access.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] data;
  logic [31:0] readData;
  logic        stall;
  logic [31:0] sramAddr;
  logic [31:0] sramWriteData;
  logic        sramRead;
  logic        sramWrite;
  logic        sramReady;
  logic [31:0] sramReadData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_cache dut (
    .clk           (clk),
    .rst           (rst),
    .memRead       (memRead),
    .memWrite      (memWrite),
    .address       (address),
    .data          (data),
    .readData      (readData),
    .stall         (stall),
    .sramAddr      (sramAddr),
    .sramWriteData (sramWriteData),
    .sramRead      (sramRead),
    .sramWrite     (sramWrite),
    .sramReady     (sramReady),
    .sramReadData  (sramReadData)
  );

  task automatic test_reset();
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; address = 32'd0; data = 32'd0;
    sramReady = 1'b0; sramReadData = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
    checks++; if (sramRead !== 1'b0) begin errors++; $display("FAIL reset_sramRead got %0b want 0", sramRead); end
    checks++; if (sramWrite !== 1'b0) begin errors++; $display("FAIL reset_sramWrite got %0b want 0", sramWrite); end
    checks++; if (readData !== 32'd0) begin errors++; $display("FAIL reset_readData got %h want 0", readData); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall got %0b want 0", stall); end
    checks++; if (sramRead !== 1'b0) begin errors++; $display("FAIL post_reset_sramRead got %0b want 0", sramRead); end
  endtask

  // A read is either a hit (lat ignored) or a miss answered on the lat-th FILL cycle with mem_word.
  task automatic test_read(input string name, input logic [31:0] addr, input logic exp_hit,
                           input int lat, input logic [31:0] mem_word);
    int stall_cnt = 0;
    int rd_cnt = 0;
    @(negedge clk); memRead = 1'b1; memWrite = 1'b0; address = addr; sramReady = 1'b0; #1;
    if (stall) stall_cnt++;
    if (sramRead) rd_cnt++;
    if (exp_hit) begin
      checks++; if (readData !== mem_word) begin errors++; $display("FAIL %s_hit_data got %h want %h", name, readData, mem_word); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s_hit_stall got %0b want 0", name, stall); end
      checks++; if (sramRead !== 1'b0) begin errors++; $display("FAIL %s_hit_sramRead got %0b want 0", name, sramRead); end
    end else begin
      for (int i = 1; i <= lat; i++) begin
        @(negedge clk); sramReady = (i == lat); sramReadData = mem_word; #1;
        if (stall) stall_cnt++;
        if (sramRead) rd_cnt++;
        checks++; if (sramAddr !== addr) begin errors++; $display("FAIL %s_sramAddr got %h want %h", name, sramAddr, addr); end
        checks++; if (sramWrite !== 1'b0) begin errors++; $display("FAIL %s_fill_sramWrite got %0b want 0", name, sramWrite); end
      end
      checks++; if (readData !== mem_word) begin errors++; $display("FAIL %s_fill_data got %h want %h", name, readData, mem_word); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s_ready_stall got %0b want 0", name, stall); end
      checks++; if (stall_cnt != lat) begin errors++; $display("FAIL %s_stall_cycles got %0d want %0d", name, stall_cnt, lat); end
      checks++; if (rd_cnt != lat) begin errors++; $display("FAIL %s_sramRead_cycles got %0d want %0d", name, rd_cnt, lat); end
    end
    @(negedge clk); memRead = 1'b0; sramReady = 1'b0; #1;
    checks++; if (readData !== 32'd0) begin errors++; $display("FAIL %s_idle_readData got %h want 0", name, readData); end
    checks++; if (stall !== 1'b0 || sramRead !== 1'b0) begin errors++; $display("FAIL %s_idle_ctl got stall=%0b rd=%0b want 0 0", name, stall, sramRead); end
  endtask

  task automatic test_write(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                            input int lat, input logic also_read);
    int stall_cnt = 0;
    int wr_cnt = 0;
    @(negedge clk); memWrite = 1'b1; memRead = also_read; address = addr; data = wdata; sramReady = 1'b0; #1;
    if (stall) stall_cnt++;
    if (sramWrite) wr_cnt++;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk); sramReady = (i == lat); #1;
      if (stall) stall_cnt++;
      if (sramWrite) wr_cnt++;
      checks++; if (sramWriteData !== wdata || sramAddr !== addr) begin errors++; $display("FAIL %s_wt_bus got %h@%h want %h@%h", name, sramWriteData, sramAddr, wdata, addr); end
      checks++; if (sramRead !== 1'b0) begin errors++; $display("FAIL %s_wt_sramRead got %0b want 0", name, sramRead); end
    end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s_ready_stall got %0b want 0", name, stall); end
    checks++; if (stall_cnt != lat) begin errors++; $display("FAIL %s_stall_cycles got %0d want %0d", name, stall_cnt, lat); end
    checks++; if (wr_cnt != lat) begin errors++; $display("FAIL %s_sramWrite_cycles got %0d want %0d", name, wr_cnt, lat); end
    @(negedge clk); memWrite = 1'b0; memRead = 1'b0; sramReady = 1'b0; #1;
    checks++; if (stall !== 1'b0 || sramWrite !== 1'b0) begin errors++; $display("FAIL %s_idle_ctl got stall=%0b wr=%0b want 0 0", name, stall, sramWrite); end
  endtask

  // While the cache is idle, readData stays 0 without memRead, and a spurious sramReady is ignored.
  task automatic test_idle_quiet();
    @(negedge clk); address = 32'h0000_0400; memRead = 1'b0; sramReady = 1'b1; #1;
    checks++; if (readData !== 32'd0) begin errors++; $display("FAIL idle_readData got %h want 0", readData); end
    @(negedge clk); sramReady = 1'b0; #1;
    checks++; if (stall !== 1'b0 || sramRead !== 1'b0 || sramWrite !== 1'b0) begin
      errors++; $display("FAIL idle_ready_ignored got stall=%0b rd=%0b wr=%0b want 0 0 0", stall, sramRead, sramWrite);
    end
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk); memRead = 1'b1; address = 32'h0000_0600; sramReady = 1'b0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midfill_req_stall got %0b want 1", stall); end
    @(negedge clk); #1;
    checks++; if (sramRead !== 1'b1) begin errors++; $display("FAIL midfill_sramRead got %0b want 1", sramRead); end
    @(negedge clk); rst = 1'b1; memRead = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (sramRead !== 1'b0) begin errors++; $display("FAIL midfill_abort_sramRead got %0b want 0", sramRead); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midfill_abort_stall got %0b want 0", stall); end
    test_read("after_rst_600", 32'h0000_0600, 1'b0, 1, 32'h6666_0600);
    test_read("after_rst_404", 32'h0000_0404, 1'b0, 1, 32'h3333_3333);
  endtask

  initial begin
    test_reset();
    test_read("cold_400", 32'h0000_0400, 1'b0, 3, 32'hDEAD_BEEF);
    test_read("hit_400", 32'h0000_0400, 1'b1, 0, 32'hDEAD_BEEF);
    test_write("wr_400", 32'h0000_0400, 32'h1234_5678, 2, 1'b0);
    test_read("hit_400_new", 32'h0000_0400, 1'b1, 0, 32'h1234_5678);
    test_idle_quiet();
    test_write("wr_500", 32'h0000_0500, 32'hAAAA_5555, 1, 1'b0);
    test_read("hit_400_kept", 32'h0000_0400, 1'b1, 0, 32'h1234_5678);
    test_read("miss_500", 32'h0000_0500, 1'b0, 2, 32'hAAAA_5555);
    test_read("evicted_400", 32'h0000_0400, 1'b0, 1, 32'h1234_5678);
    test_read("miss_404", 32'h0000_0404, 1'b0, 1, 32'h1111_1111);
    test_read("miss_504", 32'h0000_0504, 1'b0, 2, 32'h2222_2222);
    test_read("remiss_404", 32'h0000_0404, 1'b0, 1, 32'h1111_1111);
    test_read("hit_404", 32'h0000_0404, 1'b1, 0, 32'h1111_1111);
    test_write("rdwr_404", 32'h0000_0404, 32'h3333_3333, 3, 1'b1);
    test_read("hit_404_new", 32'h0000_0404, 1'b1, 0, 32'h3333_3333);
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
